// File: rtl/mini_alu_core.sv
// mini_alu_core -- two-stage (fetch / execute) mini ALU core.
//
// Fetches from an external combinational instruction ROM and executes against
// an internal register file. Adds a hardware return stack for CALL/RET, a
// valid/ready output channel, HALT, and sticky error flags.
//
// Build option: define MINI_ALU_MUL_EN to build the opcode-7 multiplier.
// Without it, opcode 7 is treated as an illegal opcode: NOP plus oIllegal.
//
// Ports:
//   Clock         rising-edge clock
//   Reset         asynchronous active-low reset
//   oIP           instruction ROM address
//   iInstruction  ROM data at oIP: {op[3:0], dest, src1, src0}, src0 in LSBs
//   oLed          LED register
//   oOutData      output-channel data
//   oOutValid     output-channel valid
//   iOutReady     output-channel consumer ready
//   oHalted       core stopped by HALT (until reset)
//   oStackErr     sticky return-stack overflow/underflow flag
//   oIllegal      sticky undefined-opcode flag
//
// Core state | meaning
// ST_RUN     | fetching and executing one instruction per cycle
// ST_HALTED  | HALT executed; IP and IR frozen until reset

module mini_alu_core #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int IP_WIDTH    = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LED_WIDTH   = 8
) (
  input  logic                      Clock,
  input  logic                      Reset,
  output logic [IP_WIDTH-1:0]       oIP,
  input  logic [4+3*ADDR_WIDTH-1:0] iInstruction,
  output logic [LED_WIDTH-1:0]      oLed,
  output logic [DATA_WIDTH-1:0]     oOutData,
  output logic                      oOutValid,
  input  logic                      iOutReady,
  output logic                      oHalted,
  output logic                      oStackErr,
  output logic                      oIllegal
);

  localparam int IW   = 4 + 3*ADDR_WIDTH;
  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_STO   = 4'h3,
    OP_BLE   = 4'h4,
    OP_JMP   = 4'h5,
    OP_LED   = 4'h6,
    OP_MUL   = 4'h7,
    OP_CALL  = 4'h8,
    OP_RET   = 4'h9,
    OP_BNRDY = 4'hA,
    OP_OUT   = 4'hB,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } coreState_t;

  coreState_t coreState, coreStateNext;

  // Execute-stage instruction and the address it was fetched from.
  logic [IW-1:0]         ir;
  logic [IP_WIDTH-1:0]   irIp;

  // Return stack: sp counts occupied entries, 0..STACK_DEPTH.
  logic [SPW-1:0]        sp;
  logic [IP_WIDTH-1:0]   stackMem [STACK_DEPTH];

  logic [DATA_WIDTH-1:0] regFile [2**ADDR_WIDTH];

  opcode_t                 op;
  logic [ADDR_WIDTH-1:0]   dest, src1, src0;
  logic [2*ADDR_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0]   regA, regB, immData;
  logic [IP_WIDTH-1:0]     immIp, destIp, retIp;
  logic                    stackFull, stackEmpty;

  logic                    regWe;
  logic [DATA_WIDTH-1:0]   regWdata;
  logic                    ledWe;
  logic                    outIssue;
  logic                    stall;
  logic                    taken;
  logic [IP_WIDTH-1:0]     target;
  logic                    push, pop;
  logic                    stackErrSet, illegalSet;

  assign op   = opcode_t'(ir[IW-1 -: 4]);
  assign dest = ir[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign src1 = ir[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign src0 = ir[ADDR_WIDTH-1:0];
  assign imm  = ir[2*ADDR_WIDTH-1:0];

  assign regA = regFile[src1];
  assign regB = regFile[src0];

  // Size casts zero-extend or truncate as needed for any parameter set.
  assign immData = DATA_WIDTH'(imm);
  assign immIp   = IP_WIDTH'(imm);
  assign destIp  = IP_WIDTH'(dest);

  assign stackFull  = (sp == SPW'(STACK_DEPTH));
  assign stackEmpty = (sp == '0);
  // Only consulted when the stack is not empty.
  assign retIp      = stackMem[IDXW'(sp - SPW'(1))];

  assign oHalted = (coreState == ST_HALTED);

  // Execute-stage decode and next-state logic.
  always_comb begin
    coreStateNext = coreState;
    regWe         = 1'b0;
    regWdata      = '0;
    ledWe         = 1'b0;
    outIssue      = 1'b0;
    stall         = 1'b0;
    taken         = 1'b0;
    target        = '0;
    push          = 1'b0;
    pop           = 1'b0;
    stackErrSet   = 1'b0;
    illegalSet    = 1'b0;

    if (coreState == ST_RUN) begin
      case (op)
        OP_NOP: ;
        OP_ADD: begin
          regWe    = 1'b1;
          regWdata = regA + regB;
        end
        OP_SUB: begin
          regWe    = 1'b1;
          regWdata = regA - regB;
        end
        OP_STO: begin
          regWe    = 1'b1;
          regWdata = immData;
        end
        OP_BLE: begin
          if (regA <= regB) begin
            taken  = 1'b1;
            target = destIp;
          end
        end
        OP_JMP: begin
          taken  = 1'b1;
          target = immIp;
        end
        OP_LED: ledWe = 1'b1;
`ifdef MINI_ALU_MUL_EN
        OP_MUL: begin
          regWe    = 1'b1;
          regWdata = regA * regB;
        end
`endif
        OP_CALL: begin
          // A CALL on a full stack is dropped entirely: no push, no jump.
          if (stackFull) begin
            stackErrSet = 1'b1;
          end else begin
            push   = 1'b1;
            taken  = 1'b1;
            target = immIp;
          end
        end
        OP_RET: begin
          if (stackEmpty) begin
            stackErrSet = 1'b1;
          end else begin
            pop    = 1'b1;
            taken  = 1'b1;
            target = retIp;
          end
        end
        OP_BNRDY: begin
          if (oOutValid && !iOutReady) begin
            taken  = 1'b1;
            target = destIp;
          end
        end
        OP_OUT: begin
          // Issue only when the channel slot is free or drains this edge.
          if (!oOutValid || iOutReady) begin
            outIssue = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        OP_HALT: begin
          coreStateNext = ST_HALTED;
          stall         = 1'b1;
        end
        default: illegalSet = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      coreState <= ST_RUN;
    end else begin
      coreState <= coreStateNext;
    end
  end

  // Fetch stage. A taken branch flushes the fetched word with a NOP bubble.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oIP  <= '0;
      ir   <= '0;
      irIp <= '0;
    end else if (taken) begin
      oIP <= target;
      ir  <= '0;
    end else if (!stall && (coreState == ST_RUN)) begin
      ir   <= iInstruction;
      irIp <= oIP;
      oIP  <= oIP + IP_WIDTH'(1);
    end
  end

  // Output channel: a new OUT may overlap the completing transfer.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oOutData  <= '0;
      oOutValid <= 1'b0;
    end else if (outIssue) begin
      oOutData  <= regB;
      oOutValid <= 1'b1;
    end else if (oOutValid && iOutReady) begin
      oOutValid <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oLed      <= '0;
      oStackErr <= 1'b0;
      oIllegal  <= 1'b0;
    end else begin
      if (ledWe) begin
        oLed <= regA[LED_WIDTH-1:0];
      end
      if (stackErrSet) begin
        oStackErr <= 1'b1;
      end
      if (illegalSet) begin
        oIllegal <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + SPW'(1);
    end else if (pop) begin
      sp <= sp - SPW'(1);
    end
  end

  // Stack storage and register file carry no reset; contents are only
  // meaningful once written.
  always_ff @(posedge Clock) begin
    if (push) begin
      stackMem[IDXW'(sp)] <= irIp + IP_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (regWe) begin
      regFile[dest] <= regWdata;
    end
  end

endmodule

// File: doc/mini_alu_core.md
# mini_alu_core

Parametrised two-stage successor of the MiniAlu datapath. It fetches from an external instruction ROM and executes against an internal register file. Adds a hardware return stack for CALL/RET, a valid/ready output channel that replaces the fixed LCD handshake, HALT, and sticky error flags. It sits between the instruction ROM and the LED/display peripherals.

## Interface
- DATA_WIDTH, 16, register/ALU width
- ADDR_WIDTH, 8, register-address field width; register file holds 2**ADDR_WIDTH entries
- IP_WIDTH, 16, instruction pointer width
- STACK_DEPTH, 4, return-stack entries (≥1)
- LED_WIDTH, 8, LED port width (≤ DATA_WIDTH)
- Instruction width is fixed: IW = 4 + 3*ADDR_WIDTH.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low. Reset=0 clears state immediately.
- oIP  out  IP_WIDTH  ROM address.
- iInstruction  in  IW  ROM data for oIP (combinational ROM). Fields: op[IW-1:IW-4], dest, src1, src0 (ADDR_WIDTH each, src0 in LSBs).
- oLed  out  LED_WIDTH  LED register.
- oOutData  out  DATA_WIDTH  output-channel data.
- oOutValid  out  1  output-channel valid.
- iOutReady  in  1  consumer ready.
- oHalted  out  1  core halted.
- oStackErr  out  1  sticky stack overflow/underflow flag.
- oIllegal  out  1  sticky undefined-opcode flag.

## Operation
- Stage F: on each edge, IR <= iInstruction and IP <= IP+1, unless stalled, flushed or halted.
- Stage X: decodes IR. Register reads are combinational. Write-back happens at the edge that ends X, so back-to-back dependent instructions need no forwarding.
- Operand notation: imm = {src1,src0} zero-extended to DATA_WIDTH. A = R[src1], B = R[src0]. All arithmetic is modulo 2**DATA_WIDTH and unsigned.
- Opcodes:
  - 0 NOP.
  - 1 ADD: R[dest] = A+B.
  - 2 SUB: R[dest] = A-B.
  - 3 STO: R[dest] = imm.
  - 4 BLE: if A ≤ B, go to dest.
  - 5 JMP: go to imm.
  - 6 LED: oLed = A[LED_WIDTH-1:0].
  - 7 MUL: R[dest] = low DATA_WIDTH bits of A*B.
  - 8 CALL: push IPx+1, then go to imm. IPx is the address of the CALL.
  - 9 RET: pop, then go to the popped value.
  - A BNRDY: go to dest if oOutValid && !iOutReady.
  - B OUT: send B on the output channel.
  - F HALT.
  - All other opcodes: behave as NOP and set oIllegal.
- Branch targets are zero-extended or truncated to IP_WIDTH.
- Taken branch (BLE, JMP, CALL, RET, BNRDY): IP <= target and IR <= NOP (flush).
- Output channel:
  - A transfer completes on an edge where oOutValid && iOutReady.
  - OUT issues when !oOutValid || iOutReady: oOutData <= B and oOutValid <= 1.
  - Otherwise OUT stalls: IP and IR are held until the channel frees.
  - With no new OUT, oOutValid clears after the transfer.
  - oOutData is held stable while oOutValid && !iOutReady.
- Return stack:
  - CALL when full: no push, no jump (acts as NOP), sets oStackErr.
  - RET when empty: acts as NOP, sets oStackErr.
- HALT: IP and IR freeze and oHalted=1 until reset. A pending output transfer still completes.

## Timing
- Reset values: oIP=0, IR=NOP, oLed=0, oOutData=0, oOutValid=0, oHalted=0, oStackErr=0, oIllegal=0, stack pointer=0. Register file is not reset.
- After Reset rises:
  - Edge 1: fetches address 0.
  - Edge 2: executes it; its result is visible at that edge.
- Throughput is one instruction per cycle. A taken branch costs 1 bubble. An OUT stall lasts until iOutReady=1.
- LED: oLed updates at the edge ending LED execution.
- OUT: oOutValid rises at the edge ending OUT execution.
- Simultaneous transfer completion and a new OUT in the same cycle: oOutValid stays 1 and oOutData takes the new value.
- IP wraps from 2**IP_WIDTH-1 to 0.
- Reset asserted mid-stall or mid-transfer: oOutValid drops immediately and the transfer is lost.

## Configuration
- MINI_ALU_MUL_EN defined: opcode 7 performs MUL.
- MINI_ALU_MUL_EN undefined: no multiplier is synthesised. Opcode 7 is illegal: NOP plus oIllegal=1, and dest is unchanged.

## Test plan
- Add to LED: STO R1,3; STO R2,5; ADD R3,R1,R2; LED R3 -> oLed=8 exactly 5 edges after reset release; oIllegal=0.
- SUB wrap-around: R1=3, R2=5, SUB R4 with src1=R1, src0=R2 -> R4=0xFFFE. BLE with A=R4, B=R1 is not taken; swapping the operands takes the branch with 1 bubble.
- Stack overflow/underflow: 5 nested CALLs with STACK_DEPTH=4 -> the 5th does not jump and oStackErr=1. Four RETs return to the correct addresses in LIFO order. A 5th RET is a NOP.
- Output backpressure: OUT R1 (0x1234) with iOutReady=0 for 10 cycles -> oOutValid=1 and oOutData=0x1234 held stable. A following OUT holds oIP. A BNRDY loop spins until iOutReady=1, then the transfer completes the next edge.
- MUL: 300*300 with MINI_ALU_MUL_EN -> R[dest]=0x5F90. Without the macro -> dest unchanged and oIllegal=1.
- Async reset and HALT: HALT -> oHalted=1 and oIP frozen. Pulsing Reset low between edges -> all outputs return to their reset values before the next edge.
